// File: rtl/gb_alu_seq_if.sv
// Request/response bundle between the decoder/sequencer and gb_alu_seq.
// Request side: start, grp, op, bit_index, a_in, b_in, flags_in.
// Response side: busy, done, res, flags_res, wr_en_flags. W = operand width.
interface gb_alu_seq_if #(
    parameter int W = 16
);
    logic         start;
    logic [1:0]   grp;
    logic [2:0]   op;
    logic [2:0]   bit_index;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic [7:0]   flags_in;
    logic         busy;
    logic         done;
    logic [W-1:0] res;
    logic [7:0]   flags_res;
    logic         wr_en_flags;

    modport master (
        output start, grp, op, bit_index, a_in, b_in, flags_in,
        input  busy, done, res, flags_res, wr_en_flags
    );

    modport slave (
        input  start, grp, op, bit_index, a_in, b_in, flags_in,
        output busy, done, res, flags_res, wr_en_flags
    );
endinterface

// File: rtl/gb_alu_seq.sv
// Sequential Game Boy ALU: 8-bit arith/logic/misc/CB ops plus 16-bit ADD/INC/DEC in two byte passes.
// Latency: 1 cycle for byte ops, 2 cycles for wide ops (busy high for the middle cycle).
// Backpressure: start is ignored while busy; there is no request queue.
// Ports: clk, rst (async, active high), bus (gb_alu_seq_if.slave; its W must equal 8*NPASS).
module gb_alu_seq #(
    parameter int NPASS  = 2,
    parameter int DAA_EN = 1,
    parameter int CB_EN  = 1
) (
    input  logic        clk,
    input  logic        rst,
    gb_alu_seq_if.slave bus
);
    localparam int W = 8 * NPASS;

    typedef enum logic {IDLE, HI} state_t;
    state_t state;

    // Operands are viewed as 16 bits regardless of W so the wide path is uniform.
    logic [15:0] a_ext, b_ext;
    logic [7:0]  a8, b8;
    logic        zin, nin, hin, cin;
    logic        unused_flag_bits;

    assign a_ext = 16'(bus.a_in);
    assign b_ext = 16'(bus.b_in);
    assign a8    = a_ext[7:0];
    assign b8    = b_ext[7:0];
    assign zin   = bus.flags_in[7];
    assign nin   = bus.flags_in[6];
    assign hin   = bus.flags_in[5];
    assign cin   = bus.flags_in[4];
    assign unused_flag_bits = &{1'b0, bus.flags_in[3:0]};

    // Single-cycle byte datapath.
    logic [7:0] r8, corr;
    logic       z, n, h, c, wr_c, illegal, wide, cx;
    logic [8:0] t9;
    logic [4:0] t5;

    always_comb begin
        r8 = a8; z = zin; n = nin; h = hin; c = cin;
        wr_c = 1'b1; illegal = 1'b0; wide = 1'b0;
        t9 = '0; t5 = '0; corr = '0; cx = 1'b0;
        unique case (bus.grp)
            2'b00: begin
                cx = cin & ((bus.op == 3'd1) | (bus.op == 3'd3));
                case (bus.op)
                    3'd0, 3'd1: begin
                        t9 = {1'b0, a8} + {1'b0, b8} + {8'd0, cx};
                        t5 = {1'b0, a8[3:0]} + {1'b0, b8[3:0]} + {4'd0, cx};
                        r8 = t9[7:0]; n = 1'b0; h = t5[4]; c = t9[8];
                    end
                    3'd2, 3'd3, 3'd7: begin
                        // Borrow shows up as bit 8 / bit 4 of the extended difference.
                        t9 = {1'b0, a8} - {1'b0, b8} - {8'd0, cx};
                        t5 = {1'b0, a8[3:0]} - {1'b0, b8[3:0]} - {4'd0, cx};
                        r8 = t9[7:0]; n = 1'b1; h = t5[4]; c = t9[8];
                    end
                    3'd4:    begin r8 = a8 & b8; n = 1'b0; h = 1'b1; c = 1'b0; end
                    3'd5:    begin r8 = a8 ^ b8; n = 1'b0; h = 1'b0; c = 1'b0; end
                    default: begin r8 = a8 | b8; n = 1'b0; h = 1'b0; c = 1'b0; end
                endcase
                z = (r8 == 8'd0);
                if (bus.op == 3'd7) r8 = a8;   // CP: compare only, A unchanged
            end
            2'b01: begin
                case (bus.op)
                    3'd0: begin r8 = {a8[6:0], a8[7]}; c = a8[7]; z = 1'b0; n = 1'b0; h = 1'b0; end
                    3'd1: begin r8 = {a8[0], a8[7:1]}; c = a8[0]; z = 1'b0; n = 1'b0; h = 1'b0; end
                    3'd2: begin r8 = {a8[6:0], cin};   c = a8[7]; z = 1'b0; n = 1'b0; h = 1'b0; end
                    3'd3: begin r8 = {cin, a8[7:1]};   c = a8[0]; z = 1'b0; n = 1'b0; h = 1'b0; end
                    3'd4: begin
                        if (DAA_EN == 0) begin
                            illegal = 1'b1;
                        end else if (!nin) begin
                            if (hin || (a8[3:0] > 4'd9)) corr[3:0] = 4'h6;
                            if (cin || (a8 > 8'h99)) begin corr[7:4] = 4'h6; c = 1'b1; end
                            r8 = a8 + corr;
                        end else begin
                            if (hin) corr[3:0] = 4'h6;
                            if (cin) corr[7:4] = 4'h6;
                            r8 = a8 - corr;
                        end
                        z = (r8 == 8'd0); h = 1'b0;
                    end
                    3'd5:    begin r8 = ~a8; n = 1'b1; h = 1'b1; end
                    3'd6:    begin n = 1'b0; h = 1'b0; c = 1'b1; end
                    default: begin n = 1'b0; h = 1'b0; c = ~cin; end
                endcase
            end
            2'b10: begin
                if (CB_EN == 0) begin
                    illegal = 1'b1;
                end else begin
                    case (bus.op)
                        3'd0:    begin r8 = {b8[6:0], b8[7]}; c = b8[7]; end
                        3'd1:    begin r8 = {b8[0], b8[7:1]}; c = b8[0]; end
                        3'd2:    begin r8 = {b8[6:0], cin};   c = b8[7]; end
                        3'd3:    begin r8 = {cin, b8[7:1]};   c = b8[0]; end
                        3'd4:    begin r8 = {b8[6:0], 1'b0};  c = b8[7]; end
                        3'd5:    begin r8 = {b8[7], b8[7:1]}; c = b8[0]; end
                        3'd6:    begin r8 = {b8[3:0], b8[7:4]}; c = 1'b0; end
                        default: begin r8 = {1'b0, b8[7:1]};  c = b8[0]; end
                    endcase
                    z = (r8 == 8'd0); n = 1'b0; h = 1'b0;
                end
            end
            default: begin
                if (CB_EN == 0) begin
                    illegal = 1'b1;
                end else begin
                    case (bus.op)
                        3'd0, 3'd6, 3'd7: begin
                            if (NPASS < 2) illegal = 1'b1;
                            else           wide = 1'b1;
                        end
                        3'd1: begin r8 = b8; z = ~b8[bus.bit_index]; n = 1'b0; h = 1'b1; end
                        3'd2: begin r8 = b8 & ~(8'd1 << bus.bit_index); wr_c = 1'b0; end
                        3'd3: begin r8 = b8 | (8'd1 << bus.bit_index);  wr_c = 1'b0; end
                        3'd4: begin r8 = b8 + 8'd1; z = (r8 == 8'd0); n = 1'b0; h = (b8[3:0] == 4'hF); end
                        default: begin r8 = b8 - 8'd1; z = (r8 == 8'd0); n = 1'b1; h = (b8[3:0] == 4'h0); end
                    endcase
                end
            end
        endcase
    end

    // Wide ops: low byte on the start edge, high byte from latched operands on the next.
    logic [8:0] lo9, hi9;
    logic [4:0] hh5;
    logic [7:0] lat_lo, lat_a_hi, lat_b_hi, lat_f;
    logic [2:0] lat_op;
    logic       lat_c;

    assign lo9 = (bus.op == 3'd0) ? ({1'b0, a8} + {1'b0, b8}) :
                 (bus.op == 3'd6) ? ({1'b0, a8} + 9'd1) : ({1'b0, a8} - 9'd1);

    always_comb begin
        hh5 = {1'b0, lat_a_hi[3:0]} + {1'b0, lat_b_hi[3:0]} + {4'd0, lat_c};
        case (lat_op)
            3'd0:    hi9 = {1'b0, lat_a_hi} + {1'b0, lat_b_hi} + {8'd0, lat_c};
            3'd6:    hi9 = {1'b0, lat_a_hi} + {8'd0, lat_c};
            default: hi9 = {1'b0, lat_a_hi} - {8'd0, lat_c};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.wr_en_flags <= 1'b0;
            bus.res         <= '0;
            bus.flags_res   <= '0;
            lat_c           <= 1'b0;
            lat_lo          <= '0;
            lat_a_hi        <= '0;
            lat_b_hi        <= '0;
            lat_f           <= '0;
            lat_op          <= '0;
        end else begin
            bus.done        <= 1'b0;
            bus.wr_en_flags <= 1'b0;
            bus.busy        <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (wide) begin
                            state    <= HI;
                            bus.busy <= 1'b1;
                            lat_lo   <= lo9[7:0];
                            lat_c    <= lo9[8];
                            lat_a_hi <= a_ext[15:8];
                            lat_b_hi <= b_ext[15:8];
                            lat_f    <= bus.flags_in & 8'hF0;
                            lat_op   <= bus.op;
                        end else if (illegal) begin
                            bus.done      <= 1'b1;
                            bus.res       <= bus.a_in;
                            bus.flags_res <= bus.flags_in & 8'hF0;
                        end else begin
                            bus.done        <= 1'b1;
                            bus.res         <= W'(r8);
                            bus.flags_res   <= {z, n, h, c, 4'b0000};
                            bus.wr_en_flags <= wr_c;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.done <= 1'b1;
                    bus.res  <= W'({hi9[7:0], lat_lo});
                    if (lat_op == 3'd0) begin
                        // ADD16 keeps Z; H/C come from bits 11/15 of the high pass.
                        bus.flags_res   <= {lat_f[7], 1'b0, hh5[4], hi9[8], 4'b0000};
                        bus.wr_en_flags <= 1'b1;
                    end else begin
                        bus.flags_res   <= lat_f;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gb_alu_seq.sv
module tb_gb_alu_seq;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    gb_alu_seq_if #(.W(16)) bus ();

    gb_alu_seq #(.NPASS(2), .DAA_EN(1), .CB_EN(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one request at the falling edge, drop start 1ns after the sampling edge.
    task automatic drive(input logic [1:0] g, input logic [2:0] o, input logic [2:0] idx,
                         input logic [15:0] a, input logic [15:0] b, input logic [7:0] f);
        @(negedge clk);
        bus.grp = g; bus.op = o; bus.bit_index = idx;
        bus.a_in = a; bus.b_in = b; bus.flags_in = f; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.res !== 16'h0000) begin errors++; $display("FAIL reset_res got %h want 0000", bus.res); end
        checks++; if (bus.flags_res !== 8'h00) begin errors++; $display("FAIL reset_flags got %h want 00", bus.flags_res); end
        checks++; if (bus.wr_en_flags !== 1'b0) begin errors++; $display("FAIL reset_wr got %b want 0", bus.wr_en_flags); end
    endtask

    task automatic test_arith();
        drive(2'b00, 3'd0, 3'd0, 16'h003A, 16'h00C6, 8'h00);
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL add_done got %b want 1", bus.done); end
        checks++; if (bus.res !== 16'h0000) begin errors++; $display("FAIL add_res got %h want 0000", bus.res); end
        checks++; if (bus.flags_res !== 8'hB0) begin errors++; $display("FAIL add_flags got %h want b0", bus.flags_res); end
        checks++; if (bus.wr_en_flags !== 1'b1) begin errors++; $display("FAIL add_wr got %b want 1", bus.wr_en_flags); end
        @(posedge clk); #1;
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL add_done_drop got %b want 0", bus.done); end
        checks++; if (bus.res !== 16'h0000) begin errors++; $display("FAIL add_res_hold got %h want 0000", bus.res); end
        drive(2'b00, 3'd3, 3'd0, 16'h003B, 16'h002A, 8'h10);
        checks++; if (bus.res !== 16'h0010) begin errors++; $display("FAIL sbc_res got %h want 0010", bus.res); end
        checks++; if (bus.flags_res !== 8'h40) begin errors++; $display("FAIL sbc_flags got %h want 40", bus.flags_res); end
        drive(2'b00, 3'd7, 3'd0, 16'h003E, 16'h003E, 8'h00);
        checks++; if (bus.res !== 16'h003E) begin errors++; $display("FAIL cp_res got %h want 003e", bus.res); end
        checks++; if (bus.flags_res !== 8'hC0) begin errors++; $display("FAIL cp_flags got %h want c0", bus.flags_res); end
        drive(2'b00, 3'd5, 3'd0, 16'h005A, 16'h005A, 8'h70);
        checks++; if (bus.res !== 16'h0000 || bus.flags_res !== 8'h80) begin errors++; $display("FAIL xor got %h/%h want 0000/80", bus.res, bus.flags_res); end
    endtask

    task automatic test_daa();
        drive(2'b01, 3'd4, 3'd0, 16'h003C, 16'h0000, 8'h00);
        checks++; if (bus.res !== 16'h0042 || bus.flags_res !== 8'h00) begin errors++; $display("FAIL daa_3c got %h/%h want 0042/00", bus.res, bus.flags_res); end
        drive(2'b01, 3'd4, 3'd0, 16'h009A, 16'h0000, 8'h00);
        checks++; if (bus.res !== 16'h0000 || bus.flags_res !== 8'h90) begin errors++; $display("FAIL daa_9a got %h/%h want 0000/90", bus.res, bus.flags_res); end
    endtask

    task automatic test_misc();
        drive(2'b01, 3'd0, 3'd0, 16'h0085, 16'h0000, 8'h80);
        checks++; if (bus.res !== 16'h000B || bus.flags_res !== 8'h10) begin errors++; $display("FAIL rlca got %h/%h want 000b/10", bus.res, bus.flags_res); end
        drive(2'b01, 3'd5, 3'd0, 16'h0035, 16'h0000, 8'h90);
        checks++; if (bus.res !== 16'h00CA || bus.flags_res !== 8'hF0) begin errors++; $display("FAIL cpl got %h/%h want 00ca/f0", bus.res, bus.flags_res); end
        drive(2'b10, 3'd6, 3'd0, 16'h0000, 16'h00F0, 8'h10);
        checks++; if (bus.res !== 16'h000F || bus.flags_res !== 8'h00) begin errors++; $display("FAIL swap got %h/%h want 000f/00", bus.res, bus.flags_res); end
        drive(2'b11, 3'd1, 3'd3, 16'h0000, 16'h0008, 8'h10);
        checks++; if (bus.res !== 16'h0008 || bus.flags_res !== 8'h30 || bus.wr_en_flags !== 1'b1) begin errors++; $display("FAIL bit3 got %h/%h/%b want 0008/30/1", bus.res, bus.flags_res, bus.wr_en_flags); end
        drive(2'b11, 3'd4, 3'd0, 16'h0000, 16'h00FF, 8'h10);
        checks++; if (bus.res !== 16'h0000 || bus.flags_res !== 8'hB0) begin errors++; $display("FAIL inc got %h/%h want 0000/b0", bus.res, bus.flags_res); end
        drive(2'b11, 3'd2, 3'd7, 16'h0000, 16'h00FF, 8'h00);
        checks++; if (bus.res !== 16'h007F || bus.wr_en_flags !== 1'b0) begin errors++; $display("FAIL res7 got %h/%b want 007f/0", bus.res, bus.wr_en_flags); end
        drive(2'b11, 3'd7, 3'd0, 16'h0000, 16'h0000, 8'h00);
        checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL dec16_busy got %b/%b want 1/0", bus.busy, bus.done); end
        @(posedge clk); #1;
        checks++; if (bus.done !== 1'b1 || bus.res !== 16'hFFFF || bus.wr_en_flags !== 1'b0) begin errors++; $display("FAIL dec16 got %b/%h/%b want 1/ffff/0", bus.done, bus.res, bus.wr_en_flags); end
    endtask

    task automatic test_wide();
        int ndone;
        drive(2'b11, 3'd0, 3'd0, 16'h0FFF, 16'h0001, 8'h80);
        checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL add16_pass1 got busy %b done %b want 1/0", bus.busy, bus.done); end
        // Stray request during busy: must be dropped.
        @(negedge clk);
        bus.grp = 2'b00; bus.op = 3'd0; bus.a_in = 16'h0001; bus.b_in = 16'h0001; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL add16_done got done %b busy %b want 1/0", bus.done, bus.busy); end
        checks++; if (bus.res !== 16'h1000 || bus.flags_res !== 8'hA0 || bus.wr_en_flags !== 1'b1) begin errors++; $display("FAIL add16_res got %h/%h/%b want 1000/a0/1", bus.res, bus.flags_res, bus.wr_en_flags); end
        ndone = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) ndone++;
        end
        checks++; if (ndone != 0 || bus.res !== 16'h1000) begin errors++; $display("FAIL add16_extra_done got %0d/%h want 0/1000", ndone, bus.res); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.grp = 2'b00; bus.op = 3'd0; bus.a_in = 16'h0001; bus.b_in = 16'h0002; bus.flags_in = 8'h00; bus.start = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.done !== 1'b1 || bus.res !== 16'h0003 || bus.flags_res !== 8'h00) begin errors++; $display("FAIL b2b_first got %b/%h/%h want 1/0003/00", bus.done, bus.res, bus.flags_res); end
        bus.op = 3'd2; bus.a_in = 16'h0005; bus.b_in = 16'h0005;
        @(posedge clk); #1;
        bus.start = 1'b0;
        checks++; if (bus.done !== 1'b1 || bus.res !== 16'h0000 || bus.flags_res !== 8'hC0) begin errors++; $display("FAIL b2b_second got %b/%h/%h want 1/0000/c0", bus.done, bus.res, bus.flags_res); end
    endtask

    task automatic test_reset_mid();
        drive(2'b11, 3'd0, 3'd0, 16'h0FFF, 16'h0001, 8'h80);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rmid_busy got %b want 1", bus.busy); end
        rst = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.res !== 16'h0000 || bus.flags_res !== 8'h00 || bus.done !== 1'b0) begin errors++; $display("FAIL rmid_clear got %b/%h/%h/%b want 0/0000/00/0", bus.busy, bus.res, bus.flags_res, bus.done); end
        @(posedge clk); #1;
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rmid_nodone got %b want 0", bus.done); end
        @(negedge clk);
        rst = 1'b0;
        drive(2'b00, 3'd0, 3'd0, 16'h0001, 16'h0001, 8'h00);
        checks++; if (bus.done !== 1'b1 || bus.res !== 16'h0002 || bus.flags_res !== 8'h00) begin errors++; $display("FAIL rmid_next got %b/%h/%h want 1/0002/00", bus.done, bus.res, bus.flags_res); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.grp = 2'b00; bus.op = 3'd0; bus.bit_index = 3'd0;
        bus.a_in = 16'h0000; bus.b_in = 16'h0000; bus.flags_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_arith();
        test_daa();
        test_misc();
        test_wide();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
